// File: rtl/wrf_checker_pkg.sv
// Shared constants and FSM state type for the WR-fabric sequential-payload checker.
package wrf_checker_pkg;

    localparam logic [1:0] C_ADR_DATA   = 2'd0;
    localparam logic [1:0] C_ADR_OOB    = 2'd1;
    localparam logic [1:0] C_ADR_STATUS = 2'd2;

    localparam int unsigned C_STAT_ERR_BIT = 1;

    localparam logic [3:0] C_W_DST0 = 4'd0;
    localparam logic [3:0] C_W_DST1 = 4'd1;
    localparam logic [3:0] C_W_DST2 = 4'd2;
    localparam logic [3:0] C_W_SRC0 = 4'd3;
    localparam logic [3:0] C_W_SRC1 = 4'd4;
    localparam logic [3:0] C_W_SRC2 = 4'd5;
    localparam logic [3:0] C_W_ETH  = 4'd6;
    localparam logic [3:0] C_W_SEQ  = 4'd7;
    localparam logic [3:0] C_W_PAY  = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAY,
        S_EVAL,
        S_DISC
    } state_t;

endpackage

// File: rtl/wrf_seq_checker.sv
// Fabric sink that checks header, sequence ID and sequential payload of each frame
// and keeps good/bad/sequence-error counters.
module wrf_seq_checker
    import wrf_checker_pkg::*;
#(
    parameter logic [15:0] g_ethertype = 16'h88f7,
    parameter int unsigned g_min_len   = 64
) (
    input  logic        clk_sys_i,
    input  logic        rst_i,
    input  logic [47:0] cfg_dst_mac_i,
    input  logic [47:0] cfg_src_mac_i,
    input  logic        clr_i,
    input  logic        snk_cyc_i,
    input  logic        snk_stb_i,
    input  logic        snk_we_i,
    input  logic [1:0]  snk_adr_i,
    input  logic [15:0] snk_dat_i,
    input  logic [1:0]  snk_sel_i,
    output logic        snk_ack_o,
    output logic        snk_stall_o,
    output logic        snk_err_o,
    output logic [31:0] cnt_good_o,
    output logic [31:0] cnt_bad_o,
    output logic [31:0] cnt_seq_err_o,
    output logic [15:0] last_seq_o,
    output logic        done_p_o,
    output logic        ok_o
);

    state_t      state_q, state_d;
    logic        cyc_q;
    logic [3:0]  w_q, w_d;
    logic [7:0]  pb_q, pb_d;
    logic [15:0] len_q, len_d;
    logic        hdr_ok_q, hdr_ok_d;
    logic        pay_ok_q, pay_ok_d;
    logic        pay_seen_q, pay_seen_d;
    logic        st_err_q, st_err_d;
    logic [15:0] seq_rx_q, seq_rx_d;
    logic [15:0] seq_exp_q, seq_exp_d;
    logic        synced_q, synced_d;
    logic [15:0] last_seq_q, last_seq_d;
    logic [31:0] good_q, good_d;
    logic [31:0] bad_q, bad_d;
    logic [31:0] serr_q, serr_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic        ack_q, ack_d;

    logic        stall;
    logic        strobe;
    logic        in_frame;
    logic        active;
    logic        seq_acc;
    logic        frame_good;
    logic [15:0] hdr_exp;

    assign stall    = (state_q == S_EVAL);
    assign strobe   = snk_cyc_i & snk_stb_i & ~stall;
    assign in_frame = (state_q == S_HDR) || (state_q == S_PAY);
    // The word strobed in the same cycle cyc rises belongs to the new frame.
    assign active   = in_frame || ((state_q == S_IDLE) && snk_cyc_i && !cyc_q);

    assign frame_good = hdr_ok_q & pay_ok_q & pay_seen_q & ~st_err_q
                      & (len_q >= 16'(g_min_len));

    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        pb_d       = pb_q;
        len_d      = len_q;
        hdr_ok_d   = hdr_ok_q;
        pay_ok_d   = pay_ok_q;
        pay_seen_d = pay_seen_q;
        st_err_d   = st_err_q;
        seq_rx_d   = seq_rx_q;
        seq_exp_d  = seq_exp_q;
        synced_d   = synced_q;
        last_seq_d = last_seq_q;
        good_d     = good_q;
        bad_d      = bad_q;
        serr_d     = serr_q;
        done_d     = 1'b0;
        ok_d       = ok_q;
        ack_d      = strobe;
        hdr_exp    = '0;
        seq_acc    = 1'b0;

        if (!in_frame) begin
            w_d        = '0;
            pb_d       = '0;
            len_d      = '0;
            hdr_ok_d   = 1'b1;
            pay_ok_d   = 1'b1;
            pay_seen_d = 1'b0;
            st_err_d   = 1'b0;
        end

        if (active && strobe && snk_we_i) begin
            case (snk_adr_i)
                C_ADR_DATA: begin
                    if (w_d < C_W_PAY) begin
                        case (w_d)
                            C_W_DST0: hdr_exp = cfg_dst_mac_i[47:32];
                            C_W_DST1: hdr_exp = cfg_dst_mac_i[31:16];
                            C_W_DST2: hdr_exp = cfg_dst_mac_i[15:0];
                            C_W_SRC0: hdr_exp = cfg_src_mac_i[47:32];
                            C_W_SRC1: hdr_exp = cfg_src_mac_i[31:16];
                            C_W_SRC2: hdr_exp = cfg_src_mac_i[15:0];
                            C_W_ETH:  hdr_exp = g_ethertype;
                            default:  hdr_exp = snk_dat_i;
                        endcase
                        if (w_d == C_W_SEQ) begin
                            seq_rx_d   = snk_dat_i;
                            pay_seen_d = 1'b1;
                            seq_acc    = 1'b1;
                        end else if (snk_dat_i != hdr_exp) begin
                            hdr_ok_d = 1'b0;
                        end
                    end else begin
                        if (snk_dat_i[15:8] != pb_d) pay_ok_d = 1'b0;
                        if (snk_sel_i[0] && (snk_dat_i[7:0] != pb_d + 8'd1)) pay_ok_d = 1'b0;
                        pb_d = pb_d + 8'd2;
                    end
                    len_d = len_d + ((snk_sel_i == 2'b11) ? 16'd2 : 16'd1);
                    if (w_d != C_W_PAY) w_d = w_d + 4'd1;
                end
                C_ADR_STATUS: begin
                    if (snk_dat_i[C_STAT_ERR_BIT]) st_err_d = 1'b1;
                end
                C_ADR_OOB: ;
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (snk_cyc_i && !cyc_q) state_d = S_HDR;
            end
            S_HDR: begin
                if (!snk_cyc_i)   state_d = S_EVAL;
                else if (seq_acc) state_d = S_PAY;
            end
            S_PAY: begin
                if (!snk_cyc_i) state_d = S_EVAL;
            end
            S_EVAL: begin
                done_d = 1'b1;
                ok_d   = frame_good;
                if (frame_good) good_d = good_q + 32'd1;
                else            bad_d  = bad_q + 32'd1;
                if (pay_seen_q) begin
                    if (synced_q && (seq_rx_q != seq_exp_q)) serr_d = serr_q + 32'd1;
                    seq_exp_d  = seq_rx_q + 16'd1;
                    synced_d   = 1'b1;
                    last_seq_d = seq_rx_q;
                end
                // A cyc that rose during the stalled EVAL cycle starts the next frame.
                state_d = snk_cyc_i ? S_HDR : S_IDLE;
            end
            S_DISC: begin
                if (!snk_cyc_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (clr_i) begin
            good_d     = '0;
            bad_d      = '0;
            serr_d     = '0;
            synced_d   = 1'b0;
            seq_exp_d  = '0;
            last_seq_d = '0;
            done_d     = 1'b0;
            ok_d       = 1'b0;
            state_d    = snk_cyc_i ? S_DISC : S_IDLE;
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            state_q    <= snk_cyc_i ? S_DISC : S_IDLE;
            cyc_q      <= 1'b0;
            w_q        <= '0;
            pb_q       <= '0;
            len_q      <= '0;
            hdr_ok_q   <= 1'b1;
            pay_ok_q   <= 1'b1;
            pay_seen_q <= 1'b0;
            st_err_q   <= 1'b0;
            seq_rx_q   <= '0;
            seq_exp_q  <= '0;
            synced_q   <= 1'b0;
            last_seq_q <= '0;
            good_q     <= '0;
            bad_q      <= '0;
            serr_q     <= '0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= snk_cyc_i;
            w_q        <= w_d;
            pb_q       <= pb_d;
            len_q      <= len_d;
            hdr_ok_q   <= hdr_ok_d;
            pay_ok_q   <= pay_ok_d;
            pay_seen_q <= pay_seen_d;
            st_err_q   <= st_err_d;
            seq_rx_q   <= seq_rx_d;
            seq_exp_q  <= seq_exp_d;
            synced_q   <= synced_d;
            last_seq_q <= last_seq_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            serr_q     <= serr_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            ack_q      <= ack_d;
        end
    end

    assign snk_ack_o     = ack_q;
    assign snk_stall_o   = stall;
    assign snk_err_o     = 1'b0;
    assign cnt_good_o    = good_q;
    assign cnt_bad_o     = bad_q;
    assign cnt_seq_err_o = serr_q;
    assign last_seq_o    = last_seq_q;
    assign done_p_o      = done_q;
    assign ok_o          = ok_q;

endmodule

// File: tb/tb_wrf_seq_checker.sv
// Randomized frame stimulus checked against a frame-level reference model.
module tb_wrf_seq_checker;

    localparam logic [47:0] DST = 48'h0150cafebabe;
    localparam logic [47:0] SRC = 48'h060203040506;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b1;
    logic [1:0]  adr = 2'd0;
    logic [15:0] dat = 16'h0000;
    logic [1:0]  sel = 2'b11;
    logic        ack, stall, err, done, ok;
    logic [31:0] c_good, c_bad, c_serr;
    logic [15:0] last_seq;

    always #5 clk = ~clk;

    wrf_seq_checker #(.g_ethertype(16'h88f7), .g_min_len(64)) dut (
        .clk_sys_i(clk), .rst_i(rst), .cfg_dst_mac_i(DST), .cfg_src_mac_i(SRC),
        .clr_i(clr), .snk_cyc_i(cyc), .snk_stb_i(stb), .snk_we_i(we),
        .snk_adr_i(adr), .snk_dat_i(dat), .snk_sel_i(sel),
        .snk_ack_o(ack), .snk_stall_o(stall), .snk_err_o(err),
        .cnt_good_o(c_good), .cnt_bad_o(c_bad), .cnt_seq_err_o(c_serr),
        .last_seq_o(last_seq), .done_p_o(done), .ok_o(ok)
    );

    int total = 0;
    int bad = 0;

    logic [7:0]  fr[$];
    int unsigned m_good, m_bad, m_serr;
    logic [15:0] m_last, m_exp;
    bit          m_sync;
    bit          m_ok_q[$];
    bit          d_ok_q[$];
    int          ack_err = 0, ack_cnt = 0, sent_words = 0;

    // Every handshake must be acked exactly on the following edge.
    always @(posedge clk) begin
        logic e;
        e = !rst && cyc && stb && !stall;
        #1;
        if (ack !== e) ack_err++;
        if (ack === 1'b1) ack_cnt++;
    end

    always @(negedge clk) if (done === 1'b1) d_ok_q.push_back(ok);

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] hdr_byte(input int i);
        logic [111:0] h;
        h = {DST, SRC, 16'h88f7};
        return h[111 - 8*i -: 8];
    endfunction

    function automatic void model_clear();
        m_good = 0; m_bad = 0; m_serr = 0; m_last = '0; m_exp = '0; m_sync = 0;
        m_ok_q.delete();
        d_ok_q.delete();
    endfunction

    function automatic void build(input logic [15:0] seq, input int len, input int flip);
        fr.delete();
        for (int i = 0; i < 14; i++) fr.push_back(hdr_byte(i));
        fr.push_back(seq[15:8]);
        fr.push_back(seq[7:0]);
        for (int k = 0; k < len - 16; k++) fr.push_back(8'(k));
        if (flip >= 0) fr[16 + flip] = fr[16 + flip] ^ 8'hff;
    endfunction

    function automatic void model_frame(input bit st_err);
        int L;
        bit runt, good;
        logic [15:0] s;
        L = fr.size();
        runt = (L < 16);
        good = !runt && !st_err && (L >= 64);
        for (int i = 0; i < 14 && i < L; i++) if (fr[i] !== hdr_byte(i)) good = 0;
        for (int k = 16; k < L; k++) if (fr[k] !== 8'(k - 16)) good = 0;
        if (!runt) begin
            s = {fr[14], fr[15]};
            if (m_sync && s != m_exp) m_serr++;
            m_exp  = s + 16'd1;
            m_sync = 1;
            m_last = s;
        end
        if (good) m_good++; else m_bad++;
        m_ok_q.push_back(good);
    endfunction

    // Sends fr as data words, then an OOB and a status word; called on a negedge.
    task automatic send_frame(input bit st_err, input int gap, input int rst_word, input int gap_after);
        int L, nw, idx, guard;
        bit did_rst, acc;
        L = fr.size();
        nw = (L + 1) / 2;
        idx = 0; guard = 0; did_rst = 0;
        cyc = 1'b1;
        while (idx < nw + 2) begin
            if (rst_word == idx && !did_rst) begin rst = 1'b1; did_rst = 1; end
            else rst = 1'b0;
            if ($urandom_range(99) < gap) stb = 1'b0;
            else begin
                stb = 1'b1;
                if (idx < nw) begin
                    adr = 2'd0;
                    dat = {fr[2*idx], (2*idx + 1 < L) ? fr[2*idx + 1] : 8'h00};
                    sel = (2*idx + 1 < L) ? 2'b11 : 2'b10;
                end else if (idx == nw) begin
                    adr = 2'd1; dat = 16'($urandom); sel = 2'b11;
                end else begin
                    adr = 2'd2; dat = st_err ? 16'h0002 : 16'h0000; sel = 2'b11;
                end
            end
            acc = stb && !stall;
            @(negedge clk);
            if (acc) begin idx++; sent_words++; end
            guard++;
            if (guard > 5000) begin
                total++; bad++;
                $display("FAIL send_frame stalled: words sent=%0d required=%0d", idx, nw + 2);
                break;
            end
        end
        rst = 1'b0; stb = 1'b0; cyc = 1'b0; adr = 2'd0; sel = 2'b11;
        repeat (gap_after) @(negedge clk);
        if (did_rst) model_clear(); else model_frame(st_err);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_clear();
        total += 7;
        if (c_good !== 32'd0)   begin bad++; $display("FAIL reset cnt_good got=%0d exp=0", c_good); end
        if (c_bad !== 32'd0)    begin bad++; $display("FAIL reset cnt_bad got=%0d exp=0", c_bad); end
        if (c_serr !== 32'd0)   begin bad++; $display("FAIL reset cnt_seq_err got=%0d exp=0", c_serr); end
        if (last_seq !== 16'd0) begin bad++; $display("FAIL reset last_seq got=%h exp=0", last_seq); end
        if (done !== 1'b0 || ok !== 1'b0) begin bad++; $display("FAIL reset done/ok got=%b%b exp=00", done, ok); end
        if (ack !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL reset ack/stall got=%b%b exp=00", ack, stall); end
        if (err !== 1'b0)       begin bad++; $display("FAIL reset snk_err got=%b exp=0", err); end
    endtask

    task automatic test_stream(input string name, input int flip_frame);
        do_clr();
        for (int i = 0; i < 20; i++) begin
            build(16'(i), int'($urandom_range(257, 64)), (i == flip_frame) ? 37 : -1);
            send_frame(0, 30, -1, 4);
        end
        total += 5;
        if (c_good !== m_good)   begin bad++; $display("FAIL %s cnt_good got=%0d exp=%0d", name, c_good, m_good); end
        if (c_bad !== m_bad)     begin bad++; $display("FAIL %s cnt_bad got=%0d exp=%0d", name, c_bad, m_bad); end
        if (c_serr !== m_serr)   begin bad++; $display("FAIL %s cnt_seq_err got=%0d exp=%0d", name, c_serr, m_serr); end
        if (last_seq !== m_last) begin bad++; $display("FAIL %s last_seq got=%h exp=%h", name, last_seq, m_last); end
        if (d_ok_q.size() != m_ok_q.size()) begin
            bad++; $display("FAIL %s done count got=%0d exp=%0d", name, d_ok_q.size(), m_ok_q.size());
        end else begin
            foreach (m_ok_q[i]) begin
                total++;
                if (d_ok_q[i] !== m_ok_q[i]) begin bad++; $display("FAIL %s ok_o frame %0d got=%b exp=%b", name, i, d_ok_q[i], m_ok_q[i]); end
            end
        end
    endtask

    task automatic test_seq();
        logic [15:0] seqs1 [4] = '{16'h0000, 16'h0001, 16'h0003, 16'h0004};
        logic [15:0] seqs2 [3] = '{16'hfffe, 16'hffff, 16'h0000};
        do_clr();
        foreach (seqs1[i]) begin build(seqs1[i], 80, -1); send_frame(0, 20, -1, 4); end
        total += 2;
        if (c_serr !== m_serr) begin bad++; $display("FAIL seq_gap cnt_seq_err got=%0d exp=%0d", c_serr, m_serr); end
        if (c_good !== m_good) begin bad++; $display("FAIL seq_gap cnt_good got=%0d exp=%0d", c_good, m_good); end
        do_clr();
        foreach (seqs2[i]) begin build(seqs2[i], 70, -1); send_frame(0, 20, -1, 4); end
        total += 2;
        if (c_serr !== m_serr)   begin bad++; $display("FAIL seq_wrap cnt_seq_err got=%0d exp=%0d", c_serr, m_serr); end
        if (last_seq !== m_last) begin bad++; $display("FAIL seq_wrap last_seq got=%h exp=%h", last_seq, m_last); end
    endtask

    task automatic test_len();
        int lens [5] = '{63, 64, 65, 62, 257};
        do_clr();
        foreach (lens[i]) begin build(16'(100 + i), lens[i], -1); send_frame(0, 25, -1, 4); end
        total += 2;
        if (c_good !== m_good) begin bad++; $display("FAIL min_len cnt_good got=%0d exp=%0d", c_good, m_good); end
        if (c_bad !== m_bad)   begin bad++; $display("FAIL min_len cnt_bad got=%0d exp=%0d", c_bad, m_bad); end
    endtask

    task automatic test_runt();
        do_clr();
        build(16'd7, 100, -1); send_frame(0, 20, -1, 4);
        build(16'd99, 100, -1);
        while (fr.size() > 10) void'(fr.pop_back());
        send_frame(0, 20, -1, 4);
        total += 2;
        if (last_seq !== m_last) begin bad++; $display("FAIL runt last_seq got=%h exp=%h", last_seq, m_last); end
        if (c_bad !== m_bad)     begin bad++; $display("FAIL runt cnt_bad got=%0d exp=%0d", c_bad, m_bad); end
        build(16'd8, 100, -1); send_frame(0, 20, -1, 4);
        total += 3;
        if (c_good !== m_good)   begin bad++; $display("FAIL runt_next cnt_good got=%0d exp=%0d", c_good, m_good); end
        if (c_serr !== m_serr)   begin bad++; $display("FAIL runt_next cnt_seq_err got=%0d exp=%0d", c_serr, m_serr); end
        if (last_seq !== m_last) begin bad++; $display("FAIL runt_next last_seq got=%h exp=%h", last_seq, m_last); end
    endtask

    task automatic test_status();
        do_clr();
        build(16'd3, 80, -1); send_frame(1, 20, -1, 4);
        build(16'd4, 80, -1); send_frame(0, 20, -1, 4);
        total += 3;
        if (c_bad !== m_bad)   begin bad++; $display("FAIL status cnt_bad got=%0d exp=%0d", c_bad, m_bad); end
        if (c_good !== m_good) begin bad++; $display("FAIL status cnt_good got=%0d exp=%0d", c_good, m_good); end
        if (c_serr !== m_serr) begin bad++; $display("FAIL status cnt_seq_err got=%0d exp=%0d", c_serr, m_serr); end
    endtask

    task automatic test_rst_mid();
        do_clr();
        build(16'd10, 90, -1); send_frame(0, 20, -1, 4);
        build(16'd11, 200, -1); send_frame(0, 20, 30, 4);
        total += 4;
        if (c_good !== 32'd0)   begin bad++; $display("FAIL rst_mid cnt_good got=%0d exp=0", c_good); end
        if (c_bad !== 32'd0)    begin bad++; $display("FAIL rst_mid cnt_bad got=%0d exp=0", c_bad); end
        if (c_serr !== 32'd0)   begin bad++; $display("FAIL rst_mid cnt_seq_err got=%0d exp=0", c_serr); end
        if (last_seq !== 16'd0) begin bad++; $display("FAIL rst_mid last_seq got=%h exp=0", last_seq); end
        build(16'd50, 90, -1); send_frame(0, 20, -1, 4);
        total += 2;
        if (c_good !== m_good) begin bad++; $display("FAIL rst_sync cnt_good got=%0d exp=%0d", c_good, m_good); end
        if (c_serr !== m_serr) begin bad++; $display("FAIL rst_sync cnt_seq_err got=%0d exp=%0d", c_serr, m_serr); end
        build(16'd52, 90, -1); send_frame(0, 20, -1, 4);
        total++;
        if (c_serr !== m_serr) begin bad++; $display("FAIL rst_resync cnt_seq_err got=%0d exp=%0d", c_serr, m_serr); end
    endtask

    task automatic test_timing();
        do_clr();
        build(16'd200, 64, -1); send_frame(0, 0, -1, 0);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL timing done at drop got=%b exp=0", done); end
        @(negedge clk);
        total += 2;
        if (stall !== 1'b1) begin bad++; $display("FAIL timing stall in eval got=%b exp=1", stall); end
        if (done !== 1'b0)  begin bad++; $display("FAIL timing done in eval got=%b exp=0", done); end
        @(negedge clk);
        total += 4;
        if (done !== 1'b1)     begin bad++; $display("FAIL timing done pulse got=%b exp=1", done); end
        if (ok !== 1'b1)       begin bad++; $display("FAIL timing ok got=%b exp=1", ok); end
        if (stall !== 1'b0)    begin bad++; $display("FAIL timing stall after eval got=%b exp=0", stall); end
        if (c_good !== m_good) begin bad++; $display("FAIL timing cnt_good got=%0d exp=%0d", c_good, m_good); end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL timing done width got=%b exp=0", done); end
    endtask

    task automatic test_clr_eval();
        do_clr();
        build(16'd1, 70, -1); send_frame(0, 10, -1, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
        total += 3;
        if (c_good !== 32'd0 || c_bad !== 32'd0) begin bad++; $display("FAIL clr_eval counters got=%0d/%0d exp=0/0", c_good, c_bad); end
        if (done !== 1'b0) begin bad++; $display("FAIL clr_eval done got=%b exp=0", done); end
        @(negedge clk);
        if (c_good !== 32'd0) begin bad++; $display("FAIL clr_eval late cnt_good got=%0d exp=0", c_good); end
        repeat (3) @(negedge clk);
        build(16'd9, 70, -1); send_frame(0, 10, -1, 4);
        total++;
        if (c_good !== m_good) begin bad++; $display("FAIL clr_eval next cnt_good got=%0d exp=%0d", c_good, m_good); end
    endtask

    task automatic test_back_to_back();
        do_clr();
        ack_err = 0; ack_cnt = 0; sent_words = 0;
        for (int i = 0; i < 8; i++) begin
            build(16'(300 + i), 2 * int'($urandom_range(128, 32)) + 1, -1);
            send_frame(0, 40, -1, (i == 7) ? 4 : 1);
        end
        total += 4;
        if (c_good !== m_good || m_good != 8) begin bad++; $display("FAIL b2b cnt_good got=%0d exp=%0d", c_good, m_good); end
        if (c_bad !== 32'd0)      begin bad++; $display("FAIL b2b cnt_bad got=%0d exp=0", c_bad); end
        if (ack_err != 0)         begin bad++; $display("FAIL b2b ack timing errors got=%0d exp=0", ack_err); end
        if (ack_cnt != sent_words) begin bad++; $display("FAIL b2b ack count got=%0d exp=%0d", ack_cnt, sent_words); end
        total++;
        if (d_ok_q.size() != 8) begin bad++; $display("FAIL b2b done count got=%0d exp=8", d_ok_q.size()); end
    endtask

    initial begin
        test_reset();
        test_stream("good_stream", -1);
        test_stream("bad_payload", 5);
        total++;
        if (d_ok_q.size() < 6 || d_ok_q[5] !== 1'b0) begin
            bad++; $display("FAIL bad_payload 6th ok_o got=%b exp=0", (d_ok_q.size() < 6) ? 1'bx : d_ok_q[5]);
        end
        test_seq();
        test_len();
        test_runt();
        test_status();
        test_rst_mid();
        test_timing();
        test_clr_eval();
        test_back_to_back();
        total++;
        if (ack_err != 0) begin bad++; $display("FAIL ack monitor errors got=%0d exp=0", ack_err); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
